// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker.
//   - sweep FSM state encoding
//   - vector / settle-counter widths and vector count
//   - helper that replaces one bit of the capture register
package tt_sweep_checker_pkg;

  localparam int TT_VEC_W   = 3;
  localparam int TT_NUM_VEC = 8;
  localparam int TT_CNT_W   = 4;

  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_DRIVE = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  // Return the capture word with entry idx replaced by the sampled response.
  function automatic logic [TT_NUM_VEC-1:0] tt_capture_bit(
    input logic [TT_NUM_VEC-1:0] cap,
    input logic [TT_VEC_W-1:0]   idx,
    input logic                  resp
  );
    logic [TT_NUM_VEC-1:0] upd;
    upd      = cap;
    upd[idx] = resp;
    return upd;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts hold cycles for the vector currently being driven.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : increment enable
//   expire     : high while the count equals SETTLE (sample point)
module tt_settle_timer
  import tt_sweep_checker_pkg::*;
#(
  parameter logic [TT_CNT_W-1:0] SETTLE = 4'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TT_CNT_W-1:0] cnt_r;

  // Hold-cycle counter; cleared at each vector boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TT_CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TT_CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(TT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == SETTLE);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive 3-input truth-table checker. Drives every {x,y,z} vector into a
// combinational unit-under-test, holds each for SETTLE+1 cycles, samples f on
// the last edge of the window, then compares the captured table with the
// expected table latched at start.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : sweep request, accepted in IDLE or DONE only
//   exp_table    : expected table, bit i = f for vector i = {x,y,z}
//   f            : response from the unit-under-test
//   x, y, z      : registered stimulus (x = MSB of vector index)
//   busy         : sweep in progress
//   done         : results valid, held until next accepted start
//   pass         : captured table equals expected table
//   table_out    : capture register (partial results visible mid-sweep)
//   mismatch     : captured XOR expected
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TT_NUM_VEC-1:0] exp_table,
  input  logic                  f,
  output logic                  x,
  output logic                  y,
  output logic                  z,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [TT_NUM_VEC-1:0] table_out,
  output logic [TT_NUM_VEC-1:0] mismatch
);

  localparam logic [TT_CNT_W-1:0] SETTLE_C = TT_CNT_W'(SETTLE);
  localparam logic [TT_VEC_W-1:0] LAST_VEC = TT_VEC_W'(TT_NUM_VEC - 1);

  tt_state_e             state_r;
  tt_state_e             state_s;
  logic [TT_VEC_W-1:0]   vec_r;
  logic [TT_NUM_VEC-1:0] cap_r;
  logic [TT_NUM_VEC-1:0] exp_r;
  logic [TT_NUM_VEC-1:0] mismatch_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;

  logic                  start_acc_s;
  logic                  expire_s;
  logic                  sample_s;
  logic                  last_s;
  logic [TT_NUM_VEC-1:0] cap_next_s;

  assign start_acc_s = start && ((state_r == TT_IDLE) || (state_r == TT_DONE));
  assign sample_s    = (state_r == TT_DRIVE) && expire_s;
  assign last_s      = sample_s && (vec_r == LAST_VEC);
  assign cap_next_s  = tt_capture_bit(cap_r, vec_r, f);

  tt_settle_timer #(
    .SETTLE (SETTLE_C)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc_s || sample_s),
    .en     (state_r == TT_DRIVE),
    .expire (expire_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= TT_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: start is ignored while DRIVE is running.
  always_comb begin
    state_s = state_r;
    case (state_r)
      TT_IDLE: begin
        if (start_acc_s) state_s = TT_DRIVE;
        else             state_s = TT_IDLE;
      end
      TT_DRIVE: begin
        if (last_s) state_s = TT_DONE;
        else        state_s = TT_DRIVE;
      end
      TT_DONE: begin
        if (start_acc_s) state_s = TT_DRIVE;
        else             state_s = TT_DONE;
      end
      default: state_s = TT_IDLE;
    endcase
  end

  // Vector, capture, expected latch and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r      <= {TT_VEC_W{1'b0}};
      cap_r      <= {TT_NUM_VEC{1'b0}};
      exp_r      <= {TT_NUM_VEC{1'b0}};
      mismatch_r <= {TT_NUM_VEC{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else if (start_acc_s) begin
      vec_r      <= {TT_VEC_W{1'b0}};
      cap_r      <= {TT_NUM_VEC{1'b0}};
      exp_r      <= exp_table;
      mismatch_r <= {TT_NUM_VEC{1'b0}};
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else if (sample_s) begin
      cap_r <= cap_next_s;
      if (last_s) begin
        // Vector stays at 7 so x,y,z hold 1,1,1 while results are shown.
        mismatch_r <= cap_next_s ^ exp_r;
        pass_r     <= (cap_next_s == exp_r);
        busy_r     <= 1'b0;
        done_r     <= 1'b1;
      end else begin
        vec_r <= vec_r + {{(TT_VEC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign x         = vec_r[2];
  assign y         = vec_r[1];
  assign z         = vec_r[0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign table_out = cap_r;
  assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: instance A uses SETTLE=1, instance B
// uses SETTLE=0. Each drives a small behavioural 3-input circuit selected by
// a mode variable (0: XOR3, 1: majority, 2: stuck at 0).
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] exp_a, exp_b;
  logic       f_a, f_b;
  logic       x_a, y_a, z_a, x_b, y_b, z_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] tab_a, mis_a, tab_b, mis_b;
  logic [1:0] mode_a, mode_b;
  logic       sel;

  logic       busy_m, done_m, pass_m;
  logic [2:0] vec_m;
  logic [7:0] tab_m, mis_m;

  int checks = 0;
  int errors = 0;
  int cyc, vbad, dcount;
  logic busy10;

  always #5 clk = ~clk;

  tt_sweep_checker #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .exp_table(exp_a), .f(f_a),
    .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .table_out(tab_a), .mismatch(mis_a)
  );

  tt_sweep_checker #(.SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .exp_table(exp_b), .f(f_b),
    .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .table_out(tab_b), .mismatch(mis_b)
  );

  function automatic logic model_f(input logic [1:0] mode, input logic a, input logic b, input logic c);
    case (mode)
      2'd0:    return a ^ b ^ c;
      2'd1:    return (a & b) | (a & c) | (b & c);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    f_a = model_f(mode_a, x_a, y_a, z_a);
    f_b = model_f(mode_b, x_b, y_b, z_b);
  end

  always_comb begin
    busy_m = sel ? busy_b : busy_a;
    done_m = sel ? done_b : done_a;
    pass_m = sel ? pass_b : pass_a;
    vec_m  = sel ? {x_b, y_b, z_b} : {x_a, y_a, z_a};
    tab_m  = sel ? tab_b : tab_a;
    mis_m  = sel ? mis_b : mis_a;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_xyz"},  {5'd0, vec_m}, 8'h00);
    check({tag, "_busy"}, {7'd0, busy_m}, 8'h00);
    check({tag, "_done"}, {7'd0, done_m}, 8'h00);
    check({tag, "_pass"}, {7'd0, pass_m}, 8'h00);
    check({tag, "_tab"},  tab_m, 8'h00);
    check({tag, "_mis"},  mis_m, 8'h00);
  endtask

  // Present start for one edge (from a negedge), then check the post-accept state.
  task automatic do_start(input string tag, input logic [7:0] e);
    if (sel) exp_b = e;
    else     exp_a = e;
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    check({tag, "_acc_busy"}, {7'd0, busy_m}, 8'h01);
    check({tag, "_acc_done"}, {7'd0, done_m}, 8'h00);
    check({tag, "_acc_tab"},  tab_m, 8'h00);
    check({tag, "_acc_xyz"},  {5'd0, vec_m}, 8'h00);
  endtask

  // Step edges after the start edge until done, an optional stop point, or a
  // cycle budget. Counts vectors that differ from cyc/(SETTLE+1).
  task automatic wait_done(input int s1, input bit chk_vec, input int pulse_at,
                           input int stop_at, output int c, output int vb);
    c  = 0;
    vb = 0;
    while (c < 200) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      set_start(c == pulse_at);
      if (c == stop_at) break;
      if (done_m) break;
      if (chk_vec && (vec_m !== 3'(c / s1))) vb++;
    end
    set_start(1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00; mode_a = 2'd0; mode_b = 2'd1; sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    // XOR3, correct expectation, SETTLE=1.
    do_start("xor", 8'h96);
    wait_done(2, 1'b1, -1, -1, cyc, vbad);
    check("xor_cycles", 8'(cyc), 8'd16);
    check("xor_vecseq", 8'(vbad), 8'd0);
    check("xor_tab", tab_m, 8'h96);
    check("xor_mis", mis_m, 8'h00);
    check("xor_pass", {7'd0, pass_m}, 8'h01);
    check("xor_busy", {7'd0, busy_m}, 8'h00);
    check("xor_xyz", {5'd0, vec_m}, 8'h07);

    // Same circuit, wrong expectation (restart from DONE).
    do_start("bad", 8'h97);
    check("bad_acc_pass", {7'd0, pass_m}, 8'h00);
    wait_done(2, 1'b1, -1, -1, cyc, vbad);
    check("bad_cycles", 8'(cyc), 8'd16);
    check("bad_pass", {7'd0, pass_m}, 8'h00);
    check("bad_mis", mis_m, 8'h01);
    check("bad_tab", tab_m, 8'h96);

    // Majority, SETTLE=0: one cycle per vector.
    sel = 1'b1;
    do_start("maj", 8'hE8);
    wait_done(1, 1'b1, -1, -1, cyc, vbad);
    check("maj_cycles", 8'(cyc), 8'd8);
    check("maj_vecseq", 8'(vbad), 8'd0);
    check("maj_tab", tab_m, 8'hE8);
    check("maj_pass", {7'd0, pass_m}, 8'h01);

    // Asynchronous reset while vector 4 is driven.
    sel = 1'b0;
    do_start("rmid", 8'h96);
    wait_done(2, 1'b1, -1, 8, cyc, vbad);
    check("rmid_vec4", {5'd0, vec_m}, 8'h04);
    check("rmid_partial", tab_m, 8'h06);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rmid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_start("rerun", 8'h96);
    wait_done(2, 1'b1, -1, -1, cyc, vbad);
    check("rerun_cycles", 8'(cyc), 8'd16);
    check("rerun_tab", tab_m, 8'h96);
    check("rerun_pass", {7'd0, pass_m}, 8'h01);

    // start pulsed during DRIVE at vector 2 is ignored.
    do_start("pulse", 8'h96);
    wait_done(2, 1'b1, 4, -1, cyc, vbad);
    check("pulse_cycles", 8'(cyc), 8'd16);
    check("pulse_vecseq", 8'(vbad), 8'd0);
    check("pulse_tab", tab_m, 8'h96);
    check("pulse_pass", {7'd0, pass_m}, 8'h01);

    // Response stuck at 0 against an all-ones expectation.
    mode_a = 2'd2;
    do_start("stk", 8'hFF);
    wait_done(2, 1'b1, -1, -1, cyc, vbad);
    check("stk_tab", tab_m, 8'h00);
    check("stk_mis", mis_m, 8'hFF);
    check("stk_pass", {7'd0, pass_m}, 8'h00);

    // start held high across completion on B: done lasts one cycle, then restart.
    sel = 1'b1;
    exp_b = 8'hE8;
    start_b = 1'b1;
    dcount = 0;
    busy10 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_b) dcount++;
      if (i == 10) busy10 = busy_b;
    end
    start_b = 1'b0;
    check("hold_done_cycles", 8'(dcount), 8'd1);
    check("hold_restart_busy", {7'd0, busy10}, 8'h01);
    wait_done(1, 1'b0, -1, -1, cyc, vbad);
    check("hold_tail_cycles", 8'(cyc), 8'd6);
    check("hold_pass", {7'd0, pass_m}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
